// File: rtl/sample_buffer_arbiter.sv
// sample_buffer_arbiter
// Arbitrates one operation per cycle on the filter's single-port sample memory.
// Writes come from the quantiser and reads come from the FIR engine.
// It keeps the circular write pointer and the stored-sample count.
// It maps history offsets to physical addresses.
// A read beyond the stored history returns zero; this is the filter's zero-padding.
module sample_buffer_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_offset,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          last_gnt;   // 0: last grant was a write, 1: last grant was a read
  logic          gnt_w;
  logic          gnt_r;
  logic          in_hist;
  logic          rd_vld_p1;
  logic          rd_zero_p1;

  // Count saturates at DEPTH; once full, new writes overwrite the oldest sample
  function automatic logic [AW:0] sat_inc(input logic [AW:0] c);
    return (c == CNT_MAX) ? c : c + (AW+1)'(1);
  endfunction

  // Round-robin grant; on contention the side not served last time wins
  always_comb begin
    in_hist = ({1'b0, rd_offset} < cnt);
    gnt_w   = !clr && wr_req && (!rd_req || last_gnt);
    gnt_r   = !clr && rd_req && (!wr_req || !last_gnt);
  end

  // Mealy memory drive; an out-of-history read is acked but leaves the memory idle
  always_comb begin
    wr_ack    = gnt_w;
    rd_ack    = gnt_r;
    mem_en    = gnt_w || (gnt_r && in_hist);
    mem_we    = gnt_w;
    mem_wdata = wr_data;
    mem_addr  = gnt_w ? wr_ptr : (wr_ptr - AW'(1) - rd_offset);
  end

  // Stage p0 -> p1: pointer/count bookkeeping and the read-response pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      last_gnt   <= 1'b1;
      rd_vld_p1  <= 1'b0;
      rd_zero_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= gnt_r;
      rd_zero_p1 <= gnt_r && !in_hist;
      if (clr) begin
        wr_ptr <= '0;
        cnt    <= '0;
      end else if (gnt_w) begin
        wr_ptr   <= wr_ptr + AW'(1);
        cnt      <= sat_inc(cnt);
        last_gnt <= 1'b0;
      end else if (gnt_r) begin
        last_gnt <= 1'b1;
      end
    end
  end

  // Zero-padding substitution on the memory read data
  always_comb begin
    rd_valid = rd_vld_p1;
    rd_data  = rd_zero_p1 ? '0 : mem_rdata;
    count    = cnt;
    empty    = (cnt == '0);
    full     = (cnt == CNT_MAX);
  end

endmodule

// File: tb/tb_sample_buffer_arbiter.sv
// Testbench for sample_buffer_arbiter: directed steps followed by randomized traffic.
// Results are compared against a history-queue reference model.
module tb_sample_buffer_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       rd_req;
  logic [7:0] rd_offset;
  logic       rd_ack;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [8:0] count;
  logic       empty;
  logic       full;

  sample_buffer_arbiter #(.DEPTH(256), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_offset(rd_offset), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read sample memory
  logic [7:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = 8'hA5;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model: the history is a queue with the newest sample at index 0
  logic [7:0] hist [$];
  int         n_written;     // writes since last clear/reset; the next slot is n_written mod 256
  bit         last_read;     // the most recent grant was a read
  bit         pend_vld;
  logic [7:0] pend_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    n_written = 0;
    last_read = 1'b1;
    pend_vld  = 1'b0;
    pend_data = '0;
  endtask

  // One clock cycle: apply inputs, check at negedge, then advance the model past the posedge
  task automatic step(input bit w, input logic [7:0] wd, input bit r, input logic [7:0] off,
                      input bit c, output bit ew, output bit er);
    bit         ih;
    logic [7:0] ed;
    int         sz;
    wr_req = w; wr_data = wd; rd_req = r; rd_offset = off; clr = c;
    sz = hist.size();
    ew = !c && w && (!r || last_read);
    er = !c && r && (!w || !last_read);
    ih = (int'(off) < sz);
    ed = ih ? hist[off] : 8'h00;
    @(negedge clk);
    chk("wr_ack", wr_ack, ew);
    chk("rd_ack", rd_ack, er);
    chk("mem_en", mem_en, ew || (er && ih));
    if (ew) begin
      chk("mem_we_w", mem_we, 1);
      chk("mem_addr_w", mem_addr, n_written % 256);
      chk("mem_wdata", mem_wdata, wd);
    end
    if (er && ih) begin
      chk("mem_we_r", mem_we, 0);
      chk("mem_addr_r", mem_addr, (n_written - 1 - int'(off)) & 255);
    end
    chk("rd_valid", rd_valid, pend_vld);
    if (pend_vld) chk("rd_data", rd_data, pend_data);
    chk("count", count, sz);
    chk("empty", empty, sz == 0);
    chk("full", full, sz == 256);
    @(posedge clk);
    #1;
    pend_vld = er;
    if (er) pend_data = ed;
    if (c) begin
      hist.delete();
      n_written = 0;
    end else if (ew) begin
      hist.push_front(wd);
      if (hist.size() > 256) void'(hist.pop_back());
      n_written++;
      last_read = 1'b0;
    end else if (er) begin
      last_read = 1'b1;
    end
  endtask

  task automatic idle();
    bit a, b;
    step(0, 8'h00, 0, 8'h00, 0, a, b);
  endtask

  task automatic wr(input logic [7:0] d);
    bit a, b;
    step(1, d, 0, 8'h00, 0, a, b);
  endtask

  task automatic rd(input logic [7:0] off);
    bit a, b;
    step(0, 8'h00, 1, off, 0, a, b);
  endtask

  // Reset asserted asynchronously mid-cycle, checked before the next edge
  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    wr_req = 0; rd_req = 0; clr = 0;
    @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit         ew, er;
    bit         wp, rp;
    logic [7:0] wd, ro;
    rst = 1'b1; clr = 0; wr_req = 0; wr_data = 0; rd_req = 0; rd_offset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Read while empty is zero-padded
    idle();
    rd(8'd0);
    idle();

    // Three samples, then offsets 0..3
    wr(8'h11); wr(8'h22); wr(8'h33);
    rd(8'd0); rd(8'd1); rd(8'd2); rd(8'd3);
    idle();

    // Wrap and saturation with 260 writes after a clear
    step(0, 8'h00, 0, 8'h00, 1, ew, er);
    for (int i = 0; i < 260; i++) wr(i[7:0]);
    rd(8'd0); rd(8'd255); rd(8'd128);
    idle();

    // Sustained contention from reset alternates W,R,...
    async_reset();
    for (int i = 0; i < 6; i++) step(1, 8'h40 + i[7:0], 1, 8'd0, 0, ew, er);
    idle();

    // Clear while a read is requested; a read granted just before still completes
    async_reset();
    for (int i = 0; i < 5; i++) wr(8'h60 + i[7:0]);
    rd(8'd1);
    step(0, 8'h00, 1, 8'd0, 1, ew, er);
    rd(8'd0);
    idle();

    // Reset in the cycle after a read ack, then contention must grant the write first
    wr(8'h77);
    rd(8'd0);
    async_reset();
    step(1, 8'h88, 1, 8'd0, 0, ew, er);
    step(0, 8'h00, 1, 8'd0, 0, ew, er);
    idle();

    // Randomized traffic: requests are held until acked, with occasional clears
    wp = 0; rp = 0; wd = 0; ro = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!wp && ($urandom_range(0, 2) != 0)) begin wp = 1; wd = 8'($urandom); end
      if (!rp && ($urandom_range(0, 1) != 0)) begin
        rp = 1;
        if ($urandom_range(0, 3) == 0) ro = 8'($urandom);
        else ro = 8'($urandom_range(0, (hist.size() + 2 > 255) ? 255 : hist.size() + 2));
      end
      step(wp, wd, rp, ro, ($urandom_range(0, 199) == 0), ew, er);
      if (ew) wp = 0;
      if (er) rp = 0;
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_buffer_arbiter.md
# sample_buffer_arbiter

Controller and arbiter for the filter's shared single-port sample memory (DEPTH x DW, synchronous read). It grants one memory operation per cycle between the quantiser write requester and the FIR engine read requester. It maintains the circular write pointer and sample count, and translates history offsets into physical addresses. Taps that reach beyond the stored history read back as zero, which implements the filter's zero-padding.

## Interface
- DEPTH, 256, number of sample entries; power of two
- AW, 8, address width = log2(DEPTH)
- DW, 8, sample width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of history (pointer and count); memory contents untouched
- wr_req  in  1  write request; held until wr_ack
- wr_data  in  DW  sample to store; stable while wr_req high
- wr_ack  out  1  combinational; write granted this cycle
- rd_req  in  1  read request; held until rd_ack
- rd_offset  in  AW  history offset; 0 = newest sample
- rd_ack  out  1  combinational; read granted this cycle
- rd_valid  out  1  registered; rd_data valid, exactly one cycle after rd_ack
- rd_data  out  DW  read sample, or 0 for out-of-history offsets
- mem_en, mem_we  out  1  memory enable / write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data (= wr_data)
- mem_rdata  in  DW  memory read data, one cycle after mem_en with mem_we=0
- count  out  AW+1  samples stored, saturating at DEPTH
- empty, full  out  1  count==0 / count==DEPTH

## Operation
- State: wr_ptr (AW bits, next write slot), count (AW+1 bits), last_gnt (1 bit: 0=write, 1=read), rd_zero_q, rd_valid_q.
- Arbitration happens each cycle when clr is low. It is round-robin with write preference:
  - Only one request asserted: that request is granted.
  - Both asserted: write wins if last_gnt=1, read wins if last_gnt=0.
  - last_gnt updates on every grant.
  - Consequence: a held rd_req waits at most one cycle behind a write, and vice versa.
- Write grant:
  - Drives mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=wr_data.
  - Next edge: wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0); count <= min(count+1, DEPTH).
  - Once full, writes continue and overwrite the oldest sample; count stays DEPTH.
- Read grant, offset in history (rd_offset < count):
  - Drives mem_en=1, mem_we=0, mem_addr = (wr_ptr - 1 - rd_offset) mod DEPTH.
- Read grant, offset out of history (rd_offset >= count, including any read while empty):
  - mem_en stays 0; rd_zero_q is set.
  - rd_ack still asserts, and rd_valid follows on the normal schedule.
- Read data path: rd_data = rd_zero_q ? 0 : mem_rdata. rd_data is don't-care while rd_valid=0.
- No grant: mem_en=0; mem_addr and mem_wdata are don't-care.
- clr high:
  - No grants that cycle (wr_ack=rd_ack=0, mem_en=0).
  - Next edge: wr_ptr <= 0, count <= 0; last_gnt is unchanged.
  - A read granted in the previous cycle still completes its rd_valid.
- rd_offset is sampled only in the grant cycle; the result uses the count from before that edge. A write and a read are never granted in the same cycle.

## Timing
- Reset values: wr_ptr=0, count=0, last_gnt=1 (write wins first contention), rd_valid=0, rd_zero_q=0, empty=1, full=0.
- wr_ack, rd_ack and the mem_* outputs are Mealy outputs of the current-cycle requests. The requester drops its req on the edge after seeing the ack.
- Write latency: a sample granted in cycle N is readable at offset 0 from a read granted in cycle N+1 or later.
- Read latency: rd_ack in cycle N gives rd_valid=1 in cycle N+1. Back-to-back reads are granted every cycle when no write contends.
- Sustained contention alternates W,R,W,R, giving each requester 50% throughput.
- rst asserted mid-transaction clears all state immediately. A rd_valid due next cycle is lost.

## Test plan
- Reset then read with rd_offset=0 -> rd_ack same cycle, mem_en=0, next cycle rd_valid=1 with rd_data=0; empty=1.
- Write 0x11, 0x22, 0x33, then reads at offsets 0, 1, 2, 3 -> mem_addr 2, 1, 0, none; rd_data 0x33, 0x22, 0x11, 0x00; count=3.
- Write 260 samples with values i[7:0] -> count=256, full=1, wr_ptr=4; offset 0 returns 0x03, offset 255 returns 0x04.
- wr_req and rd_req both held for 6 cycles from reset -> grant order W,R,W,R,W,R; each rd_valid lands exactly one cycle after its rd_ack.
- After 5 writes, assert clr while rd_req is high -> no ack that cycle; afterwards count=0 and empty=1, and a read at offset 0 returns 0.
- Assert rst in the cycle after a rd_ack -> rd_valid stays 0, count=0, and a subsequent contended cycle grants write first.
